cv32e40x_xif_fu_tracker: RTL
============================

CV32E40X_XIF_FU_TRACKER -- requirements
Module: cv32e40x_xif_fu_tracker

Interface
REQ-001 SHALL have parameter X_ID_WIDTH, default 4: width of eXtension-interface instruction IDs.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: result data width.
REQ-003 SHALL have parameter RD_WIDTH, default 5: destination register address width.
REQ-004 SHALL have parameter DEPTH, default 4: outstanding-instruction entries; a power of two, at least 2.
REQ-005 Ports SHALL be as follows, one per line, with clock and reset first:
  clk_i  in  1  clock; reset rst_n, asynchronous, active-low
  rst_n  in  1  asynchronous active-low reset
  issue_valid_i  in  1  an accepted coprocessor instruction is offered
  issue_ready_o  out  1  tracker can allocate an entry
  issue_id_i  in  X_ID_WIDTH  ID of the offered instruction
  issue_rd_i  in  RD_WIDTH  destination register of the offered instruction
  commit_valid_i  in  1  commit/kill event
  commit_id_i  in  X_ID_WIDTH  ID being committed or killed
  commit_kill_i  in  1  1 = kill, 0 = commit
  fu_valid_i  in  1  functional-unit result available
  fu_id_i  in  X_ID_WIDTH  ID of the functional-unit result
  fu_data_i  in  DATA_WIDTH  functional-unit result data
  result_valid_o  out  1  writeback result valid
  result_ready_i  in  1  core accepts the writeback
  result_id_o  out  X_ID_WIDTH  writeback ID
  result_rd_o  out  RD_WIDTH  writeback destination register
  result_data_o  out  DATA_WIDTH  writeback data
  count_o  out  clog2(DEPTH+1)  occupied entries
  err_o  out  1  sticky flag: functional-unit result with unknown ID

Function
REQ-006 SHALL hold DEPTH entries in a circular buffer in issue order (head/tail pointers wrapping modulo DEPTH); each entry holds id, rd, data, state in {FREE, ISSUED, COMMITTED, KILLED}, and a data-valid bit.
REQ-007 issue_ready_o SHALL be 1 iff count_o < DEPTH and no non-FREE entry has id == issue_id_i.
REQ-008 When issue_valid_i && issue_ready_o, SHALL write the tail entry as ISSUED with data-valid 0, then advance tail.
REQ-009 commit_valid_i SHALL move the ISSUED entry whose id matches commit_id_i to COMMITTED (kill=0) or KILLED (kill=1); events matching no ISSUED entry SHALL be ignored.
REQ-010 fu_valid_i SHALL store fu_data_i in the non-FREE entry whose id matches fu_id_i and set data-valid; results may arrive in any order; no match SHALL set err_o and discard the data.
REQ-011 Issue, commit, fu result and retire SHALL each be able to occur in the same cycle, including commit and fu result targeting the same entry; both updates SHALL take effect.
REQ-012 Head retire SHALL occur when the head entry has data-valid=1 and is either COMMITTED with output register free (!result_valid_o || result_ready_i) or KILLED; retiring frees the entry and advances head.
REQ-013 A retiring COMMITTED head SHALL load id/rd/data into the output register and set result_valid_o on the next edge; a retiring KILLED head SHALL produce no writeback.
REQ-014 Latency: fu result for a committed head at edge N SHALL give result_valid_o=1 after edge N+1; sustained throughput one result per cycle.
REQ-015 result_valid_o SHALL stay 1, with id/rd/data stable, until result_ready_i=1; it SHALL clear on handshake unless reloaded in the same cycle.
REQ-016 An ISSUED head (not yet committed or killed) or a head with data-valid=0 SHALL block retirement; younger entries SHALL wait.
REQ-017 count_o SHALL equal allocations minus retirements, updating on the edge of each event; simultaneous allocate and retire leave it unchanged.

Reset
REQ-018 rst_n low SHALL asynchronously set all entries FREE, head=tail=0, count_o=0, result_valid_o=0, result_id_o/rd/data=0, err_o=0; issue_ready_o=1 after release.
REQ-019 Reset mid-operation SHALL discard all outstanding entries and any pending writeback without emitting it.

Verification
REQ-020 Issue id 3, rd 7; commit 3; fu id 3, data 0xDEADBEEF -> next cycle result_valid_o=1 with id 3, rd 7, data 0xDEADBEEF; count_o returns to 0 after the handshake.
REQ-021 Issue ids 1, 2; fu id 2 then fu id 1; commit both -> writebacks in order id 1 then id 2.
REQ-022 Issue 5; kill 5; fu id 5 -> no writeback; count_o 1 -> 0.
REQ-023 DEPTH=4: issue 4 IDs -> issue_ready_o=0; a fifth issue is held; retiring one entry -> ready 1 and the pointer wrap is correct.
REQ-024 result_ready_i=0 for 3 cycles with two committed results pending -> first result held stable, second emitted the cycle after the handshake.
REQ-025 fu id 9 with nothing outstanding -> err_o=1 and stays 1 until reset; duplicate issue of an outstanding ID -> issue_ready_o=0.

Source files
------------

// File: rtl/cv32e40x_xif_fu_tracker.sv
// Tracks outstanding eXtension-interface coprocessor instructions in issue order,
// merges commit/kill and out-of-order functional-unit results, and retires in order.
module cv32e40x_xif_fu_tracker #(
    parameter int X_ID_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int RD_WIDTH   = 5,
    parameter int DEPTH      = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_n,
    input  logic                         issue_valid_i,
    output logic                         issue_ready_o,
    input  logic [X_ID_WIDTH-1:0]        issue_id_i,
    input  logic [RD_WIDTH-1:0]          issue_rd_i,
    input  logic                         commit_valid_i,
    input  logic [X_ID_WIDTH-1:0]        commit_id_i,
    input  logic                         commit_kill_i,
    input  logic                         fu_valid_i,
    input  logic [X_ID_WIDTH-1:0]        fu_id_i,
    input  logic [DATA_WIDTH-1:0]        fu_data_i,
    output logic                         result_valid_o,
    input  logic                         result_ready_i,
    output logic [X_ID_WIDTH-1:0]        result_id_o,
    output logic [RD_WIDTH-1:0]          result_rd_o,
    output logic [DATA_WIDTH-1:0]        result_data_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         err_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {ST_FREE, ST_ISSUED, ST_COMMITTED, ST_KILLED} state_e;

    state_e                state_q [DEPTH];
    state_e                state_d [DEPTH];
    logic [X_ID_WIDTH-1:0] id_q    [DEPTH];
    logic [X_ID_WIDTH-1:0] id_d    [DEPTH];
    logic [RD_WIDTH-1:0]   rd_q    [DEPTH];
    logic [RD_WIDTH-1:0]   rd_d    [DEPTH];
    logic [DATA_WIDTH-1:0] data_q  [DEPTH];
    logic [DATA_WIDTH-1:0] data_d  [DEPTH];
    logic [DEPTH-1:0]      dv_q, dv_d;

    logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  res_valid_q, res_valid_d;
    logic [X_ID_WIDTH-1:0] res_id_q, res_id_d;
    logic [RD_WIDTH-1:0]   res_rd_q, res_rd_d;
    logic [DATA_WIDTH-1:0] res_data_q, res_data_d;
    logic                  err_q, err_d;

    logic [DEPTH-1:0]      issue_hit, commit_hit, fu_hit;
    logic                  alloc, out_free, ret_commit, ret_kill, retire;

    // IDs are unique among occupied entries, so each hit vector is at most one-hot.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
        assign issue_hit[gi]  = (state_q[gi] != ST_FREE)   && (id_q[gi] == issue_id_i);
        assign commit_hit[gi] = (state_q[gi] == ST_ISSUED) && (id_q[gi] == commit_id_i);
        assign fu_hit[gi]     = (state_q[gi] != ST_FREE)   && (id_q[gi] == fu_id_i);
    end

    assign issue_ready_o = (count_q < CNT_W'(DEPTH)) && !(|issue_hit);
    assign alloc         = issue_valid_i && issue_ready_o;
    assign out_free      = !res_valid_q || result_ready_i;
    assign ret_commit    = (state_q[head_q] == ST_COMMITTED) && dv_q[head_q] && out_free;
    assign ret_kill      = (state_q[head_q] == ST_KILLED) && dv_q[head_q];
    assign retire        = ret_commit || ret_kill;

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        dv_d       = dv_q;
        res_valid_d = res_valid_q;
        res_id_d   = res_id_q;
        res_rd_d   = res_rd_q;
        res_data_d = res_data_q;
        err_d      = err_q | (fu_valid_i && !(|fu_hit));
        for (int i = 0; i < DEPTH; i++) begin
            state_d[i] = state_q[i];
            id_d[i]    = id_q[i];
            rd_d[i]    = rd_q[i];
            data_d[i]  = data_q[i];
            if (commit_valid_i && commit_hit[i]) begin
                state_d[i] = commit_kill_i ? ST_KILLED : ST_COMMITTED;
            end
            if (fu_valid_i && fu_hit[i]) begin
                data_d[i] = fu_data_i;
                dv_d[i]   = 1'b1;
            end
        end
        if (retire) begin
            state_d[head_q] = ST_FREE;
            dv_d[head_q]    = 1'b0;
            head_d          = head_q + PTR_W'(1);
        end
        // The tail slot is never the retiring head: that would need an empty or full buffer.
        if (alloc) begin
            state_d[tail_q] = ST_ISSUED;
            id_d[tail_q]    = issue_id_i;
            rd_d[tail_q]    = issue_rd_i;
            dv_d[tail_q]    = 1'b0;
            tail_d          = tail_q + PTR_W'(1);
        end
        if (alloc && !retire) begin
            count_d = count_q + CNT_W'(1);
        end else if (!alloc && retire) begin
            count_d = count_q - CNT_W'(1);
        end
        if (ret_commit) begin
            res_valid_d = 1'b1;
            res_id_d    = id_q[head_q];
            res_rd_d    = rd_q[head_q];
            res_data_d  = data_q[head_q];
        end else if (result_ready_i) begin
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                state_q[i] <= ST_FREE;
                id_q[i]    <= '0;
                rd_q[i]    <= '0;
                data_q[i]  <= '0;
            end
            dv_q        <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_rd_q    <= '0;
            res_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                state_q[i] <= state_d[i];
                id_q[i]    <= id_d[i];
                rd_q[i]    <= rd_d[i];
                data_q[i]  <= data_d[i];
            end
            dv_q        <= dv_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            res_rd_q    <= res_rd_d;
            res_data_q  <= res_data_d;
            err_q       <= err_d;
        end
    end

    assign result_valid_o = res_valid_q;
    assign result_id_o    = res_id_q;
    assign result_rd_o    = res_rd_q;
    assign result_data_o  = res_data_q;
    assign count_o        = count_q;
    assign err_o          = err_q;

endmodule
